// File: rtl/and16_dmux4_unit.sv
// -----------------------------------------------------------------------------
// and16_dmux4_unit
//
// Registered gate-primitive unit: a 16-bit bitwise AND, a scalar AND and a
// 1-to-4 demultiplexer, with all results captured into output registers when
// en is high. This gives downstream ALU / memory-select logic a single-cycle,
// glitch-free view of the gate results. Nothing combinational reaches an output.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset (has priority over en)
//   en         in   capture enable
//   a16, b16   in   16-bit AND operands
//   a, b       in   scalar AND operands
//   in         in   demux data input
//   sel        in   2-bit demux select
//   and16_out  out  registered a16 & b16
//   and_out    out  registered a & b
//   dmux_a..d  out  registered demux outputs (at most one high)
//   out_valid  out  high for exactly one cycle after each enabled capture
//   and16_zero out  registered (a16 & b16) == 0
//                   (present only when AND16_ZERO_FLAG_EN is defined)
//
// Optional build macro: AND16_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module and16_dmux4_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  logic        a,
  input  logic        b,
  input  logic        in,
  input  logic [1:0]  sel,
  output logic [15:0] and16_out,
  output logic        and_out,
  output logic        dmux_a,
  output logic        dmux_b,
  output logic        dmux_c,
  output logic        dmux_d,
`ifdef AND16_ZERO_FLAG_EN
  output logic        and16_zero,
`endif
  output logic        out_valid
);

  // ---------------------------------------------------------------------------
  // Next-state gate functions
  // ---------------------------------------------------------------------------
  logic [15:0] and16_next;
  logic        and_next;
  logic [3:0]  dmux_next;   // index 0..3 maps to dmux_a..dmux_d

  // Each AND16 bit is an independent gate.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_and16
      assign and16_next[gi] = a16[gi] & b16[gi];
    end
  endgenerate

  // Demux leg gi is driven only when sel selects it, so the outputs are
  // one-hot when in=1 and all zero when in=0.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dmux
      assign dmux_next[gi] = in & (sel == 2'(gi));
    end
  endgenerate

  assign and_next = a & b;

`ifdef AND16_ZERO_FLAG_EN
  logic and16_zero_next;
  logic and16_zero_reg;
  assign and16_zero_next = (and16_next == 16'h0000);
`endif

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic [15:0] and16_reg;
  logic        and_reg;
  logic [3:0]  dmux_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and16_reg <= 16'h0000;
      and_reg   <= 1'b0;
      dmux_reg  <= 4'b0000;
      valid_reg <= 1'b0;
    end else begin
      // out_valid is a one-cycle pulse that tracks en; results only load on en
      // and otherwise hold.
      valid_reg <= en;
      if (en) begin
        and16_reg <= and16_next;
        and_reg   <= and_next;
        dmux_reg  <= dmux_next;
      end
    end
  end

`ifdef AND16_ZERO_FLAG_EN
  // Same enable, reset and latency as and16_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and16_zero_reg <= 1'b0;
    end else if (en) begin
      and16_zero_reg <= and16_zero_next;
    end
  end

  assign and16_zero = and16_zero_reg;
`endif

  assign and16_out = and16_reg;
  assign and_out   = and_reg;
  assign dmux_a    = dmux_reg[0];
  assign dmux_b    = dmux_reg[1];
  assign dmux_c    = dmux_reg[2];
  assign dmux_d    = dmux_reg[3];
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_and16_dmux4_unit.sv
// -----------------------------------------------------------------------------
// tb_and16_dmux4_unit
//
// Self-checking bench for and16_dmux4_unit. Directed scenarios are followed by
// randomized traffic. Every output is compared against a behavioural model
// kept in the bench. Outputs are sampled 1 time unit after the rising edge.
// Define AND16_ZERO_FLAG_EN to also cover the and16_zero flag.
// -----------------------------------------------------------------------------
module tb_and16_dmux4_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        a;
  logic        b;
  logic        in;
  logic [1:0]  sel;
  logic [15:0] and16_out;
  logic        and_out;
  logic        dmux_a;
  logic        dmux_b;
  logic        dmux_c;
  logic        dmux_d;
  logic        out_valid;
`ifdef AND16_ZERO_FLAG_EN
  logic        and16_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  and16_dmux4_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a16       (a16),
    .b16       (b16),
    .a         (a),
    .b         (b),
    .in        (in),
    .sel       (sel),
    .and16_out (and16_out),
    .and_out   (and_out),
    .dmux_a    (dmux_a),
    .dmux_b    (dmux_b),
    .dmux_c    (dmux_c),
    .dmux_d    (dmux_d),
`ifdef AND16_ZERO_FLAG_EN
    .and16_zero(and16_zero),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural reference model: what the outputs should show after each edge
  // ---------------------------------------------------------------------------
  logic [15:0] m_and16;
  logic        m_and;
  logic [3:0]  m_dmux;   // {d,c,b,a} as a one-hot number: bit sel set when in=1
  logic        m_valid;
  logic        m_zero;

  // Packed view of all outputs: {and16, and, d, c, b, a, valid}
  function automatic logic [21:0] obs_vec();
    return {and16_out, and_out, dmux_d, dmux_c, dmux_b, dmux_a, out_valid};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {m_and16, m_and, m_dmux, m_valid};
  endfunction

  // Advance one rising edge and update the model from the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_and16 = 16'h0; m_and = 1'b0; m_dmux = 4'h0; m_valid = 1'b0; m_zero = 1'b0;
    end else begin
      m_valid = en;
      if (en) begin
        m_and16 = a16 & b16;
        m_and   = a & b;
        m_dmux  = in ? (4'd1 << sel) : 4'd0;
        m_zero  = (a16 & b16) == 16'd0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [15:0] x16,
                       input logic [15:0] y16, input logic x, input logic y,
                       input logic d, input logic [1:0] s);
    rst_n = r; en = e; a16 = x16; b16 = y16; a = x; b = y; in = d; sel = s;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 2'b01);
    m_and16 = 16'hDEAD; m_and = 1'b1; m_dmux = 4'hF; m_valid = 1'b1; m_zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_outputs edge %0d: got %h want %h", i, obs_vec(), 22'd0);
      end
`ifdef AND16_ZERO_FLAG_EN
      n_checks++;
      if (and16_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_zero edge %0d: got %b want 0", i, and16_zero);
      end
`endif
    end
    $display("reset: outputs=%h", obs_vec());
  endtask

  task automatic test_and16();
    logic [15:0] va [3] = '{16'hFFFF, 16'h0000, 16'hAAAA};
    logic [15:0] vb [3] = '{16'hFFFF, 16'hFFFF, 16'h5555};
    logic [15:0] want [3] = '{16'hFFFF, 16'h0000, 16'h0000};
    logic        wz [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, va[i], vb[i], 1'b0, 1'b0, 1'b0, 2'b00);
      tick();
      n_checks++;
      if (and16_out !== want[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL and16 %h&%h: got %h valid %b want %h valid 1", va[i], vb[i], and16_out, out_valid, want[i]);
      end
`ifdef AND16_ZERO_FLAG_EN
      n_checks++;
      if (and16_zero !== wz[i]) begin
        n_fail++;
        $display("FAIL and16_zero %h&%h: got %b want %b", va[i], vb[i], and16_zero, wz[i]);
      end
`endif
      $display("and16: %h & %h -> %h (zero flag expect %b)", va[i], vb[i], and16_out, wz[i]);
    end
  endtask

  task automatic test_and();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      drive(1'b1, 1'b1, 16'h1234, 16'h00FF, ab[1], ab[0], 1'b0, 2'b00);
      tick();
      n_checks++;
      if (and_out !== (ab == 2'b11) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL and %b&%b: got and_out %b all %h want and_out %b all %h", ab[1], ab[0], and_out, obs_vec(), ab == 2'b11, exp_vec());
      end
      $display("and: %b & %b -> %b", ab[1], ab[0], and_out);
    end
  endtask

  task automatic test_dmux();
    for (int i = 0; i < 5; i++) begin
      logic [1:0] s;
      logic       d;
      logic [3:0] want;
      s    = (i < 4) ? 2'(i) : 2'b10;
      d    = (i < 4);
      want = d ? (4'd1 << s) : 4'd0;
      drive(1'b1, 1'b1, 16'h0F0F, 16'h3333, 1'b1, 1'b0, d, s);
      tick();
      n_checks++;
      if ({dmux_d, dmux_c, dmux_b, dmux_a} !== want || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL dmux in=%b sel=%b: got dcba=%b want %b", d, s, {dmux_d, dmux_c, dmux_b, dmux_a}, want);
      end
      $display("dmux: in=%b sel=%b -> dcba=%b", d, s, {dmux_d, dmux_c, dmux_b, dmux_a});
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 16'h1111, 16'hFFFF, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      tick();
      n_checks++;
      if (and16_out !== 16'h1111 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got and16 %h valid %b want 1111 valid 0", i, and16_out, out_valid);
      end
      $display("hold %0d: and16=%h valid=%b", i, and16_out, out_valid);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    n_checks++;
    if (and_out !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: got and_out %b valid %b want 0 0", and_out, out_valid);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (and_out !== 1'b1 || out_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got and_out %b valid %b want 1 1", and_out, out_valid);
    end
    $display("reset priority: after release and_out=%b valid=%b", and_out, out_valid);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      $display("b2b %0d: a16=%h b16=%h -> %h", i, a16, b16, and16_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 15) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
`ifdef AND16_ZERO_FLAG_EN
      n_checks++;
      if (and16_zero !== m_zero) begin
        n_fail++;
        $display("FAIL random_zero %0d: got %b want %b", i, and16_zero, m_zero);
      end
`endif
      $display("rand %0d: rst_n=%b en=%b out=%h", i, rst_n, en, obs_vec());
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    m_and16 = 16'h0; m_and = 1'b0; m_dmux = 4'h0; m_valid = 1'b0; m_zero = 1'b0;
    #2;
    test_reset();
    test_and16();
    test_and();
    test_dmux();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
